simon_key_expansion: RTL and testbench

Simon round-key generator that directly consumes the `simon_seq_gen` z_j bit stream and drives its control inputs. It produces one WW-bit round key per handshake for the downstream round datapath.
- Encrypt mode: forward order k_0..k_{T-1}, starting from the user key.
- Decrypt mode: reverse order k_{T-1}..k_0, starting from the final NKW round keys.

---
 rtl/simon_key_expansion.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_simon_key_expansion.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_key_expansion.sv
// -----------------------------------------------------------------------------
// simon_key_expansion
//
// Simon round-key generator. Produces one WW-bit round key per valid/ready
// handshake, in forward order (encrypt, starting from the user key) or in
// reverse order (decrypt, starting from the final NKW round keys). The z_j
// constant bit stream comes from an external simon_seq_gen, which this block
// steers through seq_rst_o / seq_run_o / seq_mode_o.
//
// Optional feature (macro SIMON_KEXP_LAST_KEYS_EN): capture the last NKW keys
// of an encrypt schedule so they can be fed straight back as key_i for a
// decrypt run. With the macro undefined those outputs are tied to zero and
// no capture registers exist.
//
// Parameters
//   WW   word size n (16/24/32/48/64)
//   NKW  key words m (legal Simon pairs only)
//
// Ports
//   clk              clock, rising edge
//   arst_n           asynchronous active-low reset
//   start_i          begin a schedule (sampled only when idle)
//   mode_i           0 encrypt, 1 decrypt (sampled with start_i)
//   key_i            initial window, word j at [j*WW +: WW]
//   abort_i          synchronous abort back to idle
//   busy_o           schedule in progress (LOAD/RUN)
//   rk_valid_o       round key valid
//   rk_ready_i       consumer ready
//   rk_o             round key
//   rk_idx_o         true round index of rk_o
//   rk_last_o        rk_o is the final key of the schedule
//   seq_rst_o        restart the z sequence generator
//   seq_run_o        advance the z sequence generator
//   seq_mode_o       direction for the z sequence generator (latched mode)
//   seq_i            current z bit
//   last_keys_o      captured final NKW encrypt keys (word j = k_{T-m+j})
//   last_keys_vld_o  one-cycle pulse when last_keys_o is updated
// -----------------------------------------------------------------------------
module simon_key_expansion #(
  parameter int unsigned WW  = 16,
  parameter int unsigned NKW = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [NKW*WW-1:0] key_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              rk_valid_o,
  input  logic              rk_ready_i,
  output logic [WW-1:0]     rk_o,
  output logic [6:0]        rk_idx_o,
  output logic              rk_last_o,
  output logic              seq_rst_o,
  output logic              seq_run_o,
  output logic              seq_mode_o,
  input  logic              seq_i,
  output logic [NKW*WW-1:0] last_keys_o,
  output logic              last_keys_vld_o
);

  // Round count for each legal (word size, key words) pair.
  function automatic int unsigned calc_rounds(input int unsigned ww, input int unsigned nkw);
    int unsigned r;
    r = 32;
    if (ww == 16) begin
      r = 32;
    end else if (ww == 24) begin
      r = 36;
    end else if (ww == 32) begin
      r = (nkw == 3) ? 42 : 44;
    end else if (ww == 48) begin
      r = (nkw == 2) ? 52 : 54;
    end else if (ww == 64) begin
      r = (nkw == 2) ? 68 : ((nkw == 3) ? 69 : 72);
    end
    return r;
  endfunction

  localparam int unsigned T       = calc_rounds(WW, NKW);
  localparam logic [6:0]  LastIdx = 7'(T - 1);
  localparam logic [WW-1:0] RoundC3 = {{(WW-2){1'b0}}, 2'b11};

  function automatic logic [WW-1:0] ror1(input logic [WW-1:0] x);
    return {x[0], x[WW-1:1]};
  endfunction

  function automatic logic [WW-1:0] ror3(input logic [WW-1:0] x);
    return {x[2:0], x[WW-1:3]};
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_mode;
  logic [6:0]    r_cnt;
  logic [6:0]    w_cnt_nxt;
  logic [WW-1:0] r_win     [NKW];
  logic [WW-1:0] w_win_nxt [NKW];

  logic          w_run;
  logic          w_hs;
  logic          w_last;
  logic          w_capture;
  logic [WW-1:0] w_z;
  logic [WW-1:0] w_enc_tmp;
  logic [WW-1:0] w_enc_new;
  logic [WW-1:0] w_dec_tmp;
  logic [WW-1:0] w_dec_new;

  // ---------------------------------------------------------------------------
  // Handshake and control decode
  // ---------------------------------------------------------------------------
  assign w_run     = (r_state == StRun);
  assign w_hs      = w_run & rk_ready_i;
  assign w_last    = w_run & (r_cnt == LastIdx);
  assign w_capture = (r_state == StIdle) & start_i & ~abort_i;

  // ---------------------------------------------------------------------------
  // Next-word computation
  // ---------------------------------------------------------------------------
  assign w_z = {{(WW-1){1'b0}}, seq_i};

  // Forward step: window holds k_i..k_{i+m-1}, produce k_{i+m}.
  always_comb begin
    w_enc_tmp = ror3(r_win[NKW-1]);
    if (NKW == 4) begin
      w_enc_tmp = w_enc_tmp ^ r_win[1];
    end
    w_enc_tmp = w_enc_tmp ^ ror1(w_enc_tmp);
    w_enc_new = ~r_win[0] ^ w_enc_tmp ^ w_z ^ RoundC3;
  end

  // Reverse step: window holds k_i..k_{i+m-1}, recover k_{i-1} by solving the
  // forward recurrence for its oldest term.
  always_comb begin
    w_dec_tmp = ror3(r_win[NKW-2]);
    if (NKW == 4) begin
      w_dec_tmp = w_dec_tmp ^ r_win[0];
    end
    w_dec_tmp = w_dec_tmp ^ ror1(w_dec_tmp);
    w_dec_new = ~r_win[NKW-1] ^ w_dec_tmp ^ w_z ^ RoundC3;
  end

  // ---------------------------------------------------------------------------
  // Window next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < NKW; j++) begin
      w_win_nxt[j] = r_win[j];
    end
    if (w_capture) begin
      for (int j = 0; j < NKW; j++) begin
        w_win_nxt[j] = key_i[j*WW +: WW];
      end
    end else if (w_hs) begin
      if (r_mode) begin
        for (int j = NKW - 1; j > 0; j--) begin
          w_win_nxt[j] = r_win[j-1];
        end
        w_win_nxt[0] = w_dec_new;
      end else begin
        for (int j = 0; j < NKW - 1; j++) begin
          w_win_nxt[j] = r_win[j+1];
        end
        w_win_nxt[NKW-1] = w_enc_new;
      end
    end
  end

  // Counts completed handshakes; the true key index is derived from it.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_capture) begin
      w_cnt_nxt = '0;
    end else if (w_hs) begin
      w_cnt_nxt = r_cnt + 7'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state; abort overrides everything, including start_i.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        w_state_nxt = StRun;
      end
      StRun: begin
        if (w_hs && w_last) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    if (abort_i) begin
      w_state_nxt = StIdle;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= StIdle;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      for (int j = 0; j < NKW; j++) begin
        r_win[j] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_mode <= mode_i;
      end
      for (int j = 0; j < NKW; j++) begin
        r_win[j] <= w_win_nxt[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs; key fields read as zero outside RUN.
  // ---------------------------------------------------------------------------
  assign busy_o     = (r_state != StIdle);
  assign rk_valid_o = w_run;
  assign rk_last_o  = w_last;
  assign seq_rst_o  = (r_state == StLoad);
  assign seq_run_o  = w_hs & ~w_last;
  assign seq_mode_o = r_mode;

  always_comb begin
    rk_o     = '0;
    rk_idx_o = '0;
    if (w_run) begin
      rk_o     = r_mode ? r_win[NKW-1] : r_win[0];
      rk_idx_o = r_mode ? (LastIdx - r_cnt) : r_cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Last-keys capture
  // ---------------------------------------------------------------------------
`ifdef SIMON_KEXP_LAST_KEYS_EN
  logic [NKW*WW-1:0] r_last_keys;
  logic              r_last_keys_vld;

  // Shift every emitted encrypt key in at the top; after the final handshake
  // the register holds k_{T-m}..k_{T-1} with the newest key in the top word.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_last_keys     <= '0;
      r_last_keys_vld <= 1'b0;
    end else begin
      if (w_hs && !r_mode) begin
        r_last_keys <= {rk_o, r_last_keys[NKW*WW-1:WW]};
      end
      r_last_keys_vld <= w_hs & w_last & ~r_mode;
    end
  end

  assign last_keys_o     = r_last_keys;
  assign last_keys_vld_o = r_last_keys_vld;
`else
  assign last_keys_o     = '0;
  assign last_keys_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_simon_key_expansion.sv
// -----------------------------------------------------------------------------
// tb_simon_key_expansion
//
// Scoreboard bench for simon_key_expansion (WW=16, NKW=4). A behavioural z
// sequence source is attached to the seq_* ports. Each accepted start pushes
// the full expected key stream (from an absolute-index reference schedule)
// into a queue; an independent monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_simon_key_expansion;

  localparam int unsigned WW  = 16;
  localparam int unsigned NKW = 4;
  localparam int unsigned T   = 32;
  localparam int unsigned KW  = NKW * WW;

  // Period-31 z0 sequence, leftmost bit is z_0.
  localparam logic [30:0] Z0 = 31'b1111101000100101011000011100110;

  logic          clk;
  logic          arst_n;
  logic          start_i;
  logic          mode_i;
  logic [KW-1:0] key_i;
  logic          abort_i;
  logic          busy_o;
  logic          rk_valid_o;
  logic          rk_ready_i;
  logic [WW-1:0] rk_o;
  logic [6:0]    rk_idx_o;
  logic          rk_last_o;
  logic          seq_rst_o;
  logic          seq_run_o;
  logic          seq_mode_o;
  logic          seq_i;
  logic [KW-1:0] last_keys_o;
  logic          last_keys_vld_o;

  simon_key_expansion #(
    .WW  (WW),
    .NKW (NKW)
  ) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .start_i         (start_i),
    .mode_i          (mode_i),
    .key_i           (key_i),
    .abort_i         (abort_i),
    .busy_o          (busy_o),
    .rk_valid_o      (rk_valid_o),
    .rk_ready_i      (rk_ready_i),
    .rk_o            (rk_o),
    .rk_idx_o        (rk_idx_o),
    .rk_last_o       (rk_last_o),
    .seq_rst_o       (seq_rst_o),
    .seq_run_o       (seq_run_o),
    .seq_mode_o      (seq_mode_o),
    .seq_i           (seq_i),
    .last_keys_o     (last_keys_o),
    .last_keys_vld_o (last_keys_vld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference helpers
  // ---------------------------------------------------------------------------
  function automatic logic z_bit(input int j);
    int r;
    r = ((j % 31) + 31) % 31;
    return Z0[30 - r];
  endfunction

  function automatic logic [WW-1:0] rotr(input logic [WW-1:0] x, input int s);
    return (x >> s) | (x << (WW - s));
  endfunction

  // Behavioural z source: resets on seq_rst_o, steps on seq_run_o.
  int z_idx;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      z_idx <= 0;
    end else if (seq_rst_o) begin
      z_idx <= seq_mode_o ? int'(T - NKW - 1) : 0;
    end else if (seq_run_o) begin
      z_idx <= seq_mode_o ? z_idx - 1 : z_idx + 1;
    end
  end
  assign seq_i = z_bit(z_idx);

  // Full forward schedule k_0..k_{T-1} from a user key.
  logic [WW-1:0] ref_k [T];
  task automatic compute_ref(input logic [KW-1:0] key);
    logic [WW-1:0] tmp;
    for (int i = 0; i < int'(NKW); i++) ref_k[i] = key[i*WW +: WW];
    for (int i = NKW; i < int'(T); i++) begin
      tmp = rotr(ref_k[i-1], 3) ^ ref_k[i-3];
      tmp = tmp ^ rotr(tmp, 1);
      ref_k[i] = 16'hFFFC ^ {15'd0, z_bit(i - NKW)} ^ ref_k[i-4] ^ tmp;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WW-1:0] rk;
    logic [6:0]    idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic          enc;
    logic [KW-1:0] keys;
  } lk_t;

  exp_t exp_q[$];
  lk_t  lk_q[$];

  int n_chk   = 0;
  int n_err   = 0;
  int n_start = 0;
  int rst_cnt = 0;
  bit rand_ready_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sched(input logic mode);
    exp_t e;
    lk_t  l;
    for (int i = 0; i < int'(T); i++) begin
      e.rk   = mode ? ref_k[T-1-i] : ref_k[i];
      e.idx  = mode ? 7'(T - 1 - i) : 7'(i);
      e.last = (i == int'(T) - 1);
      exp_q.push_back(e);
    end
    l.enc  = ~mode;
    l.keys = {ref_k[T-1], ref_k[T-2], ref_k[T-3], ref_k[T-4]};
    lk_q.push_back(l);
  endtask

  // Monitor: samples on the falling edge, decoupled from stimulus.
  initial begin
    exp_t          e;
    lk_t           l;
    int            run_cnt;
    bit            stall_prev;
    bit            after_last;
    logic [WW-1:0] p_rk;
    logic [6:0]    p_idx;
    logic          p_last;
    run_cnt    = 0;
    stall_prev = 1'b0;
    after_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        stall_prev = 1'b0;
        after_last = 1'b0;
      end else begin
        if (seq_rst_o) begin
          rst_cnt++;
          run_cnt = 0;
          chk("rst_run_exclusive", seq_run_o, 1'b0);
        end
        if (after_last) begin
          after_last = 1'b0;
          chk("valid_after_last", rk_valid_o, 1'b0);
          chk("busy_after_last", busy_o, 1'b0);
          if (lk_q.size() > 0) begin
            l = lk_q.pop_front();
`ifdef SIMON_KEXP_LAST_KEYS_EN
            chk("last_keys_vld", last_keys_vld_o, l.enc);
            if (l.enc) chk("last_keys", last_keys_o, l.keys);
`else
            chk("last_keys_vld_off", last_keys_vld_o, 1'b0);
            chk("last_keys_off", last_keys_o, 64'd0);
`endif
          end
        end
        if (stall_prev && rk_valid_o) begin
          chk("stall_rk", rk_o, p_rk);
          chk("stall_idx", rk_idx_o, p_idx);
          chk("stall_last", rk_last_o, p_last);
        end
        if (rk_valid_o && rk_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_key", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("rk", rk_o, e.rk);
            chk("rk_idx", rk_idx_o, e.idx);
            chk("rk_last", rk_last_o, e.last);
            if (e.last) begin
              chk("seq_run_count", run_cnt, T - 1);
              after_last = 1'b1;
            end
          end
        end
        if (seq_run_o) run_cnt++;
        stall_prev = rk_valid_o & ~rk_ready_i;
        p_rk       = rk_o;
        p_idx      = rk_idx_o;
        p_last     = rk_last_o;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready_en) rk_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_valid"}, rk_valid_o, 1'b0);
    chk({tag, "_rk"}, rk_o, 16'd0);
    chk({tag, "_idx"}, rk_idx_o, 7'd0);
    chk({tag, "_last"}, rk_last_o, 1'b0);
    chk({tag, "_seq_rst"}, seq_rst_o, 1'b0);
    chk({tag, "_seq_run"}, seq_run_o, 1'b0);
    chk({tag, "_seq_mode"}, seq_mode_o, 1'b0);
    chk({tag, "_lk"}, last_keys_o, 64'd0);
    chk({tag, "_lk_vld"}, last_keys_vld_o, 1'b0);
  endtask

  // Expectations must already be pushed; ref_k is not touched here.
  task automatic start_run(input logic mode, input logic [KW-1:0] key);
    n_start++;
    start_i = 1'b1;
    mode_i  = mode;
    key_i   = key;
    step();
    start_i = 1'b0;
    mode_i  = 1'($urandom_range(0, 1));
    key_i   = {$urandom, $urandom};
    chk("load_seq_rst", seq_rst_o, 1'b1);
    chk("load_valid", rk_valid_o, 1'b0);
    chk("load_busy", busy_o, 1'b1);
    step();
    chk("run_valid", rk_valid_o, 1'b1);
    chk("run_seq_rst", seq_rst_o, 1'b0);
  endtask

  task automatic wait_done();
    int budget;
    budget = 500;
    while (busy_o && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      chk("schedule_timeout", busy_o, 1'b0);
      arst_n = 1'b0;
      #2;
      arst_n = 1'b1;
    end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic flush();
    exp_q.delete();
    lk_q.delete();
  endtask

  logic [KW-1:0] key;
  logic [KW-1:0] dkey;
  logic          mode;
  int            budget;

  initial begin
    arst_n     = 1'b1;
    start_i    = 1'b0;
    mode_i     = 1'b0;
    key_i      = '0;
    abort_i    = 1'b0;
    rk_ready_i = 1'b1;
    #1;
    arst_n = 1'b0;
    #11;
    check_zero_outputs("reset");
    arst_n = 1'b1;
    step();

    // Published test vector, ready held high.
    key = 64'h1918_1110_0908_0100;
    compute_ref(key);
    push_sched(1'b0);
    exp_q[0].rk = 16'h0100;
    exp_q[1].rk = 16'h0908;
    exp_q[2].rk = 16'h1110;
    exp_q[3].rk = 16'h1918;
    exp_q[4].rk = 16'h71C3;
    start_run(1'b0, key);
    wait_done();

    // Decrypt from k_28..k_31 of the same key: reversed stream.
    dkey = {ref_k[T-1], ref_k[T-2], ref_k[T-3], ref_k[T-4]};
    push_sched(1'b1);
    exp_q[T-1].rk = 16'h0100;
    start_run(1'b1, dkey);
    wait_done();

    // Random keys and modes under random backpressure, back to back.
    rand_ready_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      key  = {$urandom, $urandom};
      mode = 1'(r % 2);
      compute_ref(key);
      dkey = {ref_k[T-1], ref_k[T-2], ref_k[T-3], ref_k[T-4]};
      push_sched(mode);
      start_run(mode, mode ? dkey : key);
      wait_done();
    end
    rand_ready_en = 1'b0;
    rk_ready_i    = 1'b1;

    // start_i during RUN with a different key and mode is ignored.
    key = {$urandom, $urandom};
    compute_ref(key);
    push_sched(1'b0);
    start_run(1'b0, key);
    step();
    step();
    start_i = 1'b1;
    mode_i  = 1'b1;
    key_i   = ~key;
    step();
    start_i = 1'b0;
    wait_done();

    // Abort while idx 10 is presented, restart two cycles later.
    key = {$urandom, $urandom};
    compute_ref(key);
    push_sched(1'b0);
    start_run(1'b0, key);
    budget = 100;
    while (!(rk_valid_o && rk_idx_o == 7'd10) && budget > 0) begin
      step();
      budget--;
    end
    chk("abort_reach_idx10", rk_idx_o, 7'd10);
    abort_i    = 1'b1;
    rk_ready_i = 1'b0;
    step();
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_valid", rk_valid_o, 1'b0);
    chk("abort_seq_rst", seq_rst_o, 1'b0);
    flush();
    step();
    rk_ready_i = 1'b1;
    key = {$urandom, $urandom};
    compute_ref(key);
    push_sched(1'b0);
    start_run(1'b0, key);
    wait_done();

    // Asynchronous reset mid-schedule (decrypt, so seq_mode_o is 1 beforehand).
    key = {$urandom, $urandom};
    compute_ref(key);
    dkey = {ref_k[T-1], ref_k[T-2], ref_k[T-3], ref_k[T-4]};
    push_sched(1'b1);
    start_run(1'b1, dkey);
    for (int i = 0; i < 6; i++) step();
    chk("pre_reset_mode", seq_mode_o, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    flush();
    #3;
    arst_n = 1'b1;
    step();

    // One more encrypt after the reset to show full recovery.
    key = {$urandom, $urandom};
    compute_ref(key);
    push_sched(1'b0);
    start_run(1'b0, key);
    wait_done();
    step();

    chk("seq_rst_pulses", rst_cnt, n_start);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

endmodule
